// File: rtl/rtc_burst_bus.sv
// rtc_burst_bus: drives a multiplexed address/data RTC bus (a_d/cs/rd/wr strobes)
// to transfer a burst of consecutive registers to or from an internal word buffer.
// Each register takes ADDR (PHASE_CYC) + GAP (1) + DATA (PHASE_CYC) + REC (PHASE_CYC).
module rtc_burst_bus #(
    parameter int DATA_W    = 8,
    parameter int NREG      = 16,
    parameter int PHASE_CYC = 4,
    localparam int IDX_W    = $clog2(NREG),
    localparam int CNT_W    = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_mode,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    input  logic              buf_wr_en,
    input  logic [IDX_W-1:0]  buf_wr_idx,
    input  logic [DATA_W-1:0] buf_wr_data,
    input  logic [IDX_W-1:0]  buf_rd_idx,
    output logic [DATA_W-1:0] buf_rd_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);

    localparam int PH_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] NREG_C  = CNT_W'(NREG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_REC,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PH_W-1:0]   phase;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt_lat;
    logic [DATA_W-1:0] base_lat;
    logic              wr_lat;
    logic [DATA_W-1:0] mem [NREG];

    logic              accept;
    logic              abort_hit;
    logic              phase_last;
    logic              rd_sample;
    logic [CNT_W-1:0]  idx_inc;
    logic [CNT_W-1:0]  cnt_in;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] cur_addr;

    // Burst acceptance, abort qualification and per-register bookkeeping
    always_comb begin
        accept     = (state == S_IDLE) && start && !abort;
        abort_hit  = abort && (state != S_IDLE) && (state != S_FIN);
        phase_last = (phase == PH_LAST);
        rd_sample  = (state == S_DATA) && !wr_lat && phase_last && !abort;
        idx_inc    = idx + CNT_W'(1);
        cnt_in     = (count > NREG_C) ? NREG_C : count;
        widx       = idx[IDX_W-1:0];
        cur_addr   = base_lat + DATA_W'(idx);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Phase counter, burst parameters latched at start, register index, abort flag
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            idx      <= '0;
            cnt_lat  <= '0;
            base_lat <= '0;
            wr_lat   <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            // phase restarts at every state change so each phase counts from zero
            if ((state_nx != state) || (state == S_IDLE)) begin
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end

            if (accept) begin
                wr_lat   <= wr_mode;
                base_lat <= base_addr;
                cnt_lat  <= cnt_in;
                idx      <= '0;
                aborted  <= 1'b0;
            end else if (abort_hit) begin
                aborted  <= 1'b1;
            end else if ((state == S_REC) && phase_last) begin
                idx      <= idx_inc;
            end
        end
    end

    // Next-state logic and bus strobes
    always_comb begin
        state_nx = state;
        a_d      = 1'b1;
        cs       = 1'b1;
        rd       = 1'b1;
        wr       = 1'b1;
        ad_oe    = 1'b0;
        ad_out   = '0;
        busy     = (state != S_IDLE) && (state != S_FIN);
        done     = (state == S_FIN);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                // an empty burst spends one silent busy cycle here, then finishes
                if (cnt_lat != '0) begin
                    a_d    = 1'b0;
                    cs     = 1'b0;
                    wr     = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = cur_addr;
                end
                if (abort || (cnt_lat == '0)) begin
                    state_nx = S_FIN;
                end else if (phase_last) begin
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                state_nx = abort ? S_FIN : S_DATA;
            end
            S_DATA: begin
                cs = 1'b0;
                if (wr_lat) begin
                    wr     = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = mem[widx];
                end else begin
                    rd = 1'b0;
                end
                if (abort) begin
                    state_nx = S_FIN;
                end else if (phase_last) begin
                    state_nx = S_REC;
                end
            end
            S_REC: begin
                if (abort) begin
                    state_nx = S_FIN;
                end else if (phase_last) begin
                    state_nx = (idx_inc < cnt_lat) ? S_ADDR : S_FIN;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Word buffer: host loads while idle, read bursts capture ad_in, registered host read
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                mem[k] <= '0;
            end
            buf_rd_data <= '0;
        end else begin
            if (rd_sample) begin
                mem[widx] <= ad_in;
            end else if (buf_wr_en && !busy) begin
                mem[buf_wr_idx] <= buf_wr_data;
            end
            buf_rd_data <= mem[buf_rd_idx];
        end
    end

endmodule
